// File: rtl/ram_burst_controller.sv
// Fixed-length SRAM burst sequencer: one block request at a time, reads return one word per cycle, writes pull one word per cycle.
// Latency: first read word two cycles after the request edge, writes issue from the next cycle; last word flagged with last.
// Backpressure: none inside a burst; dropping req_op aborts. Optional RAM_BURST_CRITICAL_WORD_FIRST_EN starts at the requested word.
module ram_burst_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_rw,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_req,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  last,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]      K_LAST     = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_TAIL,
        S_WR,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        k_q, k_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    vld_q, vld_d;
    logic [CNT_W-1:0]        offset;
    logic [ADDR_WIDTH-1:0]   word_addr;

    // Low bits of addr_q hold the starting word; they stay zero unless critical-word-first is built in.
    always_comb begin
        offset    = addr_q[CNT_W-1:0] + k_q;
        word_addr = {addr_q[ADDR_WIDTH-1:CNT_W], offset};
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        addr_d     = addr_q;
        vld_d      = 1'b0;
        write_req  = 1'b0;
        read_valid = 1'b0;
        last       = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        read_data  = '0;

        case (state_q)
            S_IDLE: begin
                k_d = '0;
                if (req_op) begin
                    state_d = req_rw ? S_WR : S_RD;
`ifdef RAM_BURST_CRITICAL_WORD_FIRST_EN
                    addr_d  = req_addr;
`else
                    addr_d  = req_addr & ALIGN_MASK;
`endif
                end
            end
            S_RD: begin
                if (!req_op) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                end else begin
                    sram_en    = 1'b1;
                    sram_addr  = word_addr;
                    vld_d      = 1'b1;
                    read_valid = vld_q;
                    read_data  = sram_rdata;
                    k_d        = k_q + CNT_W'(1);
                    if (k_q == K_LAST) state_d = S_RD_TAIL;
                end
            end
            S_RD_TAIL: begin
                if (!req_op) begin
                    state_d = S_IDLE;
                end else begin
                    read_valid = vld_q;
                    read_data  = sram_rdata;
                    last       = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_WR: begin
                if (!req_op) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                end else begin
                    write_req  = 1'b1;
                    sram_en    = 1'b1;
                    sram_we    = 1'b1;
                    sram_addr  = word_addr;
                    sram_wdata = write_data;
                    k_d        = k_q + CNT_W'(1);
                    if (k_q == K_LAST) begin
                        last    = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            // Wait for the arbiter to release req_op so a stale request cannot re-trigger.
            S_HOLD: begin
                if (!req_op) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_ram_burst_controller.sv
// Directed bench for ram_burst_controller with a registered SRAM model and a shadow memory for expected data.
module tb_ram_burst_controller;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int BL = 8;
`ifdef RAM_BURST_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_op;
    logic [AW-1:0] req_addr;
    logic          req_rw;
    logic [DW-1:0] write_data;
    logic          write_req;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          last;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    logic [DW-1:0] mem       [0:255];
    logic [DW-1:0] model_mem [0:255];
    logic          preload;
    int            n_chk  = 0;
    int            n_pass = 0;

    ram_burst_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_rw     (req_rw),
        .write_data (write_data),
        .write_req  (write_req),
        .read_data  (read_data),
        .read_valid (read_valid),
        .last       (last),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
        end else if (sram_en) begin
            if (sram_we) mem[sram_addr[7:0]] <= sram_wdata;
            else         sram_rdata <= mem[sram_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        assert (act === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {sram_en, sram_we, write_req, read_valid, last};
    endfunction

    function automatic logic [AW-1:0] waddr(input logic [AW-1:0] a, input int k);
        int st;
        st = CWF ? int'(a[2:0]) : 0;
        return (a & ~AW'(BL - 1)) | AW'((st + k) % BL);
    endfunction

    task automatic run_read(input logic [AW-1:0] a, input int hold, input int rst_at);
        logic [4:0]    e;
        logic [AW-1:0] wa;
        req_op   = 1'b1;
        req_rw   = 1'b0;
        req_addr = a;
        for (int n = 1; n <= BL + 1; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                req_addr = ~a;
                req_rw   = 1'b1;
            end
            if (n == rst_at) begin
                rst_n  = 1'b0;
                req_op = 1'b0;
                #1;
                chk("rst_async_outputs", {strobes(), sram_addr, sram_wdata, read_data}, '0);
                return;
            end
            @(negedge clk);
            e = {n <= BL, 1'b0, 1'b0, n >= 2, n == BL + 1};
            chk("rd_strobes", strobes(), e);
            if (n <= BL) chk("rd_addr", sram_addr, waddr(a, n - 1));
            if (n >= 2) begin
                wa = waddr(a, n - 2);
                chk("rd_data", read_data, model_mem[wa[7:0]]);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(posedge clk); #1;
            if (h == hold) req_op = 1'b0;
            @(negedge clk);
            chk("hold_strobes", strobes(), '0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_strobes", strobes(), '0);
    endtask

    task automatic run_write(input logic [AW-1:0] a, input int abort, input logic [DW-1:0] dbase);
        logic [AW-1:0] wa;
        logic          live;
        req_op   = 1'b1;
        req_rw   = 1'b1;
        req_addr = a;
        for (int n = 1; n <= BL; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                req_addr = ~a;
                req_rw   = 1'b0;
            end
            live       = (abort == 0) || (n < abort);
            write_data = dbase + DW'(n - 1);
            wa         = waddr(a, n - 1);
            if (n == abort) req_op = 1'b0;
            else model_mem[wa[7:0]] = write_data;
            @(negedge clk);
            chk("wr_strobes", strobes(), {live, live, live, 1'b0, live && (n == BL)});
            if (live) begin
                chk("wr_addr", sram_addr, wa);
                chk("wr_wdata", sram_wdata, write_data);
            end
            if (n == abort) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("abort_idle_strobes", strobes(), '0);
                return;
            end
        end
        @(posedge clk); #1;
        req_op = 1'b0;
        @(negedge clk);
        chk("wr_hold_strobes", strobes(), '0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_idle_strobes", strobes(), '0);
    endtask

    initial begin
        preload    = 1'b1;
        rst_n      = 1'b0;
        req_op     = 1'b0;
        req_rw     = 1'b0;
        req_addr   = '0;
        write_data = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = DW'(i);
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {strobes(), sram_addr, sram_wdata, read_data}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_release_outputs", {strobes(), sram_addr}, '0);

        run_read(16'h0013, 0, 0);
        run_write(16'h0040, 0, 32'h0000_00A0);
        run_read(16'h0040, 0, 0);
        run_read(16'h0016, 0, 0);

        run_write(16'h0050, 4, 32'h0000_00C0);
        @(posedge clk); #1;
        run_read(16'h0050, 0, 0);

        run_read(16'h0020, 3, 0);

        run_read(16'h0030, 0, 5);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_outputs", {strobes(), sram_addr}, '0);
        @(posedge clk); #1;
        run_read(16'h0008, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_burst_controller.md
# ram_burst_controller

Memory-side sequencer for the shared main-memory bus. It accepts one block request at a time from the memory arbiter and runs it as a fixed-length burst on a single-port synchronous SRAM. For reads it returns one word per cycle; for writes it pulls one word per cycle from the requester. It drives the bus `last` strobe that ends the arbiter's grant.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width
- `ADDR_WIDTH`, 16, word address width
- `BURST_LEN`, 8, words per burst; power of two, 2..256

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_op`  in  1  request active, held by the arbiter for the whole burst
- `req_addr`  in  ADDR_WIDTH  requested word address
- `req_rw`  in  1  0 = read, 1 = write
- `write_data`  in  DATA_WIDTH  write word, valid in the same cycle as `write_req`
- `write_req`  out  1  pulls the next write word this cycle
- `read_data`  out  DATA_WIDTH  read word
- `read_valid`  out  1  `read_data` is valid this cycle
- `last`  out  1  final word of the burst
- `sram_en`  out  1  SRAM access enable
- `sram_we`  out  1  SRAM write enable
- `sram_addr`  out  ADDR_WIDTH  SRAM word address
- `sram_wdata`  out  DATA_WIDTH  SRAM write data
- `sram_rdata`  in  DATA_WIDTH  SRAM read data; registered, 1-cycle latency

## Operation
- Width rule: L = log2(BURST_LEN). Base = `req_addr` with its low L bits cleared. Word k address = base | ((start + k) mod BURST_LEN), where start = 0 (see Configuration).
- States:
  - IDLE:
    - `req_op`=1 → RD if `req_rw`=0, WR if `req_rw`=1.
    - `req_addr` and `req_rw` are latched at this edge.
    - Later changes to `req_addr` or `req_rw` are ignored.
  - RD:
    - `sram_en`=1, `sram_we`=0, `sram_addr` = word k; counter k = 0..BURST_LEN-1.
    - A one-stage valid pipe drives `read_valid`, and `read_data` = `sram_rdata`.
    - After issuing word BURST_LEN-1 → RD_TAIL.
  - RD_TAIL: presents the final word with `read_valid`=1 and `last`=1 → HOLD.
  - WR:
    - `write_req`=`sram_en`=`sram_we`=1, `sram_addr` = word k, `sram_wdata` = `write_data` (combinational).
    - `last`=1 on k = BURST_LEN-1 → HOLD.
  - HOLD: all strobes 0; stays until `req_op`=0, then → IDLE. This prevents re-triggering on a stale request.
- Abort: if `req_op` drops in RD, RD_TAIL or WR, go to IDLE next edge.
  - No `last` is issued.
  - Already-written words remain written.
  - An in-flight read word is discarded (`read_valid` forced 0).
- Outside the states above, every output is 0 and `read_data` is don't-care.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, valid pipe 0, every output 0 (`sram_addr` 0).
- Reset mid-burst: outputs go to 0 immediately. No partial write is issued after assertion.
- Edge E0 samples `req_op`=1 in IDLE; "cycle n" is the nth cycle after E0.
- Read burst:
  - `sram_en` in cycles 1..BURST_LEN.
  - `read_valid` in cycles 2..BURST_LEN+1, one word per cycle, no gaps.
  - `last` in cycle BURST_LEN+1.
- Write burst:
  - `write_req`/`sram_we` in cycles 1..BURST_LEN.
  - `last` in cycle BURST_LEN, coincident with the final write.
- HOLD is entered at the edge after `last`. If `req_op` is already 0 there, it lasts one cycle (→ IDLE). Minimum request-to-request spacing: 2 idle cycles.
- `req_op` must fall within one cycle of `last`; a higher-level request reasserted while in HOLD is not accepted until after IDLE.

## Configuration
- `RAM_BURST_CRITICAL_WORD_FIRST_EN` defined: start = `req_addr[L-1:0]`.
  - The burst begins at the requested word and wraps modulo BURST_LEN within the aligned block.
  - Applies to reads and writes.
- Not defined: start = 0. Bursts always run base..base+BURST_LEN-1 regardless of the low bits of `req_addr`.

## Test plan
- Reset with SRAM preloaded mem[i]=i, then read `req_addr`=0x0013, BURST_LEN=8:
  - `read_valid` in cycles 2..9.
  - Data 0x10..0x17.
  - `last` in cycle 9 only.
- Write `req_addr`=0x0040 supplying 0xA0..0xA7 on `write_req`:
  - `sram_we` in cycles 1..8 at 0x40..0x47.
  - `last` in cycle 8.
  - Read-back returns 0xA0..0xA7.
- Macro defined, read `req_addr`=0x0016:
  - Addresses 0x16, 0x17, 0x10..0x15.
  - `last` with data 0x15.
- `req_op` dropped in cycle 4 of a write:
  - Only 3 writes issued, no `last`.
  - IDLE next cycle; a new request at cycle 6 is accepted normally.
- `req_op` held high 3 cycles after `last`:
  - Stays in HOLD with all strobes 0.
  - Restarts only after `req_op` falls and rises again.
- `rst_n` asserted in cycle 5 of a read: all outputs 0 asynchronously; after release, a new read burst is correct.
